// File: rtl/audio_pkg.sv
// Shared constants for the 1-bit sigma-delta audio receive path.
package audio_pkg;

  localparam int          DLOG_DEF  = 6;
  localparam int          W_DEF     = 2 * DLOG_DEF + 1;
  localparam int          R_DEF     = 1 << DLOG_DEF;
  localparam logic [7:0]  MID_SCALE = 8'h80;

endpackage

// File: rtl/audio_in_if.sv
// Pin-side and PCM-side signals of the audio receiver.
interface audio_in_if;

  logic       di;
  logic       fb;
  logic [7:0] pcm;
  logic       valid;
  logic       ear;

  modport master (input di, output fb, output pcm, output valid, output ear);
  modport slave  (output di, input fb, input pcm, input valid, input ear);

endinterface

// File: rtl/audio_in_cic2.sv
// Second-order CIC decimator: two integrators at the bit rate, two combs at the frame rate.
module cic2
  import audio_pkg::*;
#(
  parameter int DLOG = DLOG_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_x,
  output logic [2*DLOG:0]     o_y,
  output logic                o_frame
);

  localparam int W = 2 * DLOG + 1;

  logic [W-1:0]    r_i1_p0;
  logic [W-1:0]    r_i2_p0;
  logic [W-1:0]    r_d1;
  logic [W-1:0]    r_d2;
  logic [DLOG-1:0] r_cnt;
  logic [W-1:0]    w_c1;
  logic [W-1:0]    w_y;
  logic            w_frame;

  // Frame cycle is the last count of the decimation period.
  assign w_frame = &r_cnt;

  // Combs read the registered i2; modulo-2^W wrap cancels in the differences.
  assign w_c1 = r_i2_p0 - r_d1;
  assign w_y  = w_c1 - r_d2;

  assign o_y     = w_y;
  assign o_frame = w_frame;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_i1_p0 <= '0;
      r_i2_p0 <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_cnt   <= '0;
    end else begin
      r_i1_p0 <= r_i1_p0 + W'(i_x);
      r_i2_p0 <= r_i2_p0 + r_i1_p0;
      r_cnt   <= r_cnt + DLOG'(1);
      if (w_frame) begin
        r_d1 <= r_i2_p0;
        r_d2 <= w_c1;
      end
    end
  end

endmodule

// File: rtl/audio_in.sv
// Ear-line receiver: synchronises the comparator bit, closes the RC loop, decimates to 8-bit PCM.
module audio_in
  import audio_pkg::*;
#(
  parameter int         DLOG = DLOG_DEF,
  parameter logic [7:0] HI   = 8'hA0,
  parameter logic [7:0] LO   = 8'h60
) (
  input  logic          clock,
  input  logic          reset,
  audio_in_if.master    bus
);

  localparam int W = 2 * DLOG + 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_fb;
  logic [7:0]    r_pcm_p1;
  logic          r_vld_p1;
  logic          r_ear;
  logic [W-1:0]  w_y;
  logic          w_frame;
  logic [7:0]    w_pcm;

  // Full scale R^2 is the only value with the top bit set; clamp it instead of wrapping to 0.
  function automatic logic [7:0] sat_pcm(input logic [W-1:0] y);
    if (y >= (W'(1) << (2 * DLOG)))
      return 8'hFF;
    else
      return y[2*DLOG-1 -: 8];
  endfunction

  function automatic logic ear_next(input logic [7:0] s, input logic cur);
    if (s >= HI)
      return 1'b1;
    else if (s <= LO)
      return 1'b0;
    else
      return cur;
  endfunction

  cic2 #(.DLOG(DLOG)) u_cic2 (
    .clock   (clock),
    .reset   (reset),
    .i_x     (r_s2),
    .o_y     (w_y),
    .o_frame (w_frame)
  );

  assign w_pcm = sat_pcm(w_y);

  // Stage p0: synchroniser and loop feedback; stage p1: PCM output and ear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_fb     <= 1'b0;
      r_pcm_p1 <= 8'h00;
      r_vld_p1 <= 1'b0;
      r_ear    <= 1'b0;
    end else begin
      r_s1     <= bus.di;
      r_s2     <= r_s1;
      r_fb     <= r_s2;
      r_vld_p1 <= w_frame;
      if (w_frame) begin
        r_pcm_p1 <= w_pcm;
        r_ear    <= ear_next(w_pcm, r_ear);
      end
    end
  end

  assign bus.fb    = r_fb;
  assign bus.pcm   = r_pcm_p1;
  assign bus.valid = r_vld_p1;
  assign bus.ear   = r_ear;

endmodule

// File: tb/tb_audio_in.sv
// Directed bench for audio_in: reset, constant/patterned bitstreams, hysteresis, mid-frame reset, feedback delay.
module tb_audio_in;
  import audio_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  audio_in_if bus();

  audio_in dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int mode   = 1;
  int ph     = 0;
  int n;
  logic [2:0] dh = 3'b000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample point is 1 time unit after the edge; then drive the next di.
  task automatic tick();
    @(posedge clock);
    #1;
    dh = {dh[1:0], bus.di};
    ph++;
    case (mode)
      0: bus.di = 1'b0;
      1: bus.di = 1'b1;
      2: bus.di = ph[0];
      3: bus.di = (ph % 4 == 0);
      4: bus.di = (ph % 4 != 0);
      default: bus.di = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (bus.valid !== 1'b1 && cnt < 200);
    check("valid_timeout", 16'(bus.valid), 16'h1);
  endtask

  task automatic skip_valids(input int k);
    int c;
    for (int i = 0; i < k; i++) wait_valid(c);
  endtask

  initial begin
    bus.di = 1'b1;
    reset  = 1'b1;

    // 1: reset held with di high
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_do",    16'(bus.pcm),   16'h00);
      check("rst_valid", 16'(bus.valid), 16'h0);
      check("rst_ear",   16'(bus.ear),   16'h0);
      check("rst_fb",    16'(bus.fb),    16'h0);
    end

    // 2: all zeros, first strobe at R, spacing R
    mode   = 0;
    bus.di = 1'b0;
    reset  = 1'b0;
    wait_valid(n);
    check("first_valid_cycle", 16'(n), 16'd64);
    check("zero_do1", 16'(bus.pcm), 16'h00);
    wait_valid(n);
    check("valid_spacing1", 16'(n), 16'd64);
    check("zero_do2", 16'(bus.pcm), 16'h00);
    tick();
    check("strobe_one_cycle", 16'(bus.valid), 16'h0);
    wait_valid(n);
    check("valid_spacing2", 16'(n), 16'd63);
    check("zero_do3", 16'(bus.pcm), 16'h00);

    // 3: all ones saturates to full scale
    mode = 1;
    skip_valids(2);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      check("ones_sat", 16'(bus.pcm), 16'hFF);
    end
    check("ones_ear", 16'(bus.ear), 16'h1);
    for (int i = 0; i < 10; i++) tick();
    check("hold_valid_low", 16'(bus.valid), 16'h0);
    check("hold_do", 16'(bus.pcm), 16'hFF);

    // 4: 50% toggling gives mid-scale, ear holds
    mode = 2;
    skip_valids(3);
    wait_valid(n);
    check("half_do", 16'(bus.pcm), 16'(MID_SCALE));
    check("half_ear_hold", 16'(bus.ear), 16'h1);

    // 5: 1-in-4, 3-in-4, back to 50%
    mode = 3;
    skip_valids(3);
    wait_valid(n);
    check("quarter_do", 16'(bus.pcm), 16'h40);
    check("quarter_ear", 16'(bus.ear), 16'h0);
    mode = 4;
    skip_valids(3);
    wait_valid(n);
    check("three_q_do", 16'(bus.pcm), 16'hC0);
    check("three_q_ear", 16'(bus.ear), 16'h1);
    mode = 2;
    skip_valids(3);
    wait_valid(n);
    check("hyst_do", 16'(bus.pcm), 16'h80);
    check("hyst_ear", 16'(bus.ear), 16'h1);

    // 6: one-cycle reset at cnt=30 with di high
    mode = 1;
    skip_valids(3);
    wait_valid(n);
    check("pre_rst_do", 16'(bus.pcm), 16'hFF);
    for (int i = 0; i < 30; i++) tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", 16'(bus.valid), 16'h0);
    check("midrst_do",    16'(bus.pcm),   16'h00);
    check("midrst_ear",   16'(bus.ear),   16'h0);
    reset = 1'b0;
    wait_valid(n);
    check("restart_spacing", 16'(n), 16'd64);
    check("restart_do", 16'(bus.pcm), 16'h72);
    check("restart_ear", 16'(bus.ear), 16'h0);

    // 7: feedback is di delayed three cycles
    mode = 5;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("fb_delay", 16'(bus.fb), 16'(dh[2]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
